fir_filter_pipelined: RTL and testbench

//  Parametrised, pipelined, run-time-programmable FIR low-pass filter; next generation of the fixed 15-tap

---
 rtl/fir_filter_pipelined.sv | 164 ++++++++++++++++
 tb/tb_fir_filter_pipelined.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_pipelined.sv
// Programmable NTAPS-tap FIR low-pass filter; signed samples in and out over valid/ready; FIR_SAT_EN adds round+saturate.
// Latency: 3 clocks from input accept to out_valid when unstalled; throughput one sample per clock.
// Backpressure: the whole pipeline and in_ready stall together whenever out_valid is held and out_ready is low.
module fir_filter_pipelined #(
   parameter int NTAPS = 15,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [DW-1:0]        in_data,
   output logic                        in_ready,
   input  logic                        coef_we,
   input  logic [$clog2(NTAPS)-1:0]    coef_addr,
   input  logic signed [CW-1:0]        coef_data,
   output logic                        out_valid,
   output logic signed [OUT_W-1:0]     out_data,
   input  logic                        out_ready,
   output logic                        sat
);

   localparam int AW = DW + CW + $clog2(NTAPS);   // full-precision sum
   localparam int PW = DW + CW;                   // one product
   localparam int IW = $clog2(NTAPS);
   // one extra address bit so NTAPS itself is representable for the range test
   localparam logic [IW:0] NTAPS_A = (IW + 1)'(NTAPS);

   logic signed [DW-1:0]    x    [NTAPS];
   logic signed [CW-1:0]    coef [NTAPS];
   logic signed [PW-1:0]    p    [NTAPS];
   logic signed [AW-1:0]    sum_c;
   logic signed [AW-1:0]    acc;
   logic signed [OUT_W-1:0] f_data;
   logic                    en;
   logic                    accept;
   logic                    v0;
   logic                    v1;
   logic                    v2;

   // A stage may move only when the output register is empty or being drained.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;

   // Delay line shifts only on an accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) x[k] <= '0;
      end else if (accept) begin
         x[0] <= in_data;
         for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
      end
   end

   // Coefficient RAM; out-of-range addresses are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
      end else if (coef_we && ({1'b0, coef_addr} < NTAPS_A)) begin
         coef[coef_addr] <= coef_data;
      end
   end

   // Marks that the delay line now holds a fresh sample awaiting the multiply stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0 <= 1'b0;
      end else if (en) begin
         v0 <= accept;
      end
   end

   // S1: one signed product per tap; coefficients are sampled here, so a write lands on the next capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) p[k] <= '0;
         v1 <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < NTAPS; k++) p[k] <= PW'(x[k]) * PW'(coef[k]);
         v1 <= v0;
      end
   end

   // Sign-extended sum of all products at full precision (cannot overflow AW).
   always_comb begin
      sum_c = '0;
      for (int k = 0; k < NTAPS; k++) sum_c = sum_c + AW'(p[k]);
   end

   // S2: register the adder tree result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         v2  <= 1'b0;
      end else if (en) begin
         acc <= sum_c;
         v2  <= v1;
      end
   end

`ifdef FIR_SAT_EN
   // Working width keeps one headroom bit for the rounding add and covers the output range.
   localparam int EW = (AW + 1 > OUT_W + 1) ? AW + 1 : OUT_W + 1;
   localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : EW'(0);
   localparam logic signed [EW-1:0] MAXV = EW'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [EW-1:0] MINV = ~MAXV;

   logic signed [EW-1:0] rnd_c;
   logic signed [EW-1:0] shf_c;
   logic                 f_sat;

   // Round half up, arithmetic shift, then clamp into the signed output range.
   always_comb begin
      rnd_c  = EW'(acc) + RND;
      shf_c  = rnd_c >>> SHIFT;
      f_data = OUT_W'(shf_c);
      f_sat  = 1'b0;
      if (shf_c > MAXV) begin
         f_data = {1'b0, {(OUT_W-1){1'b1}}};
         f_sat  = 1'b1;
      end else if (shf_c < MINV) begin
         f_data = {1'b1, {(OUT_W-1){1'b0}}};
         f_sat  = 1'b1;
      end
   end

   // Clamp flag travels with its sample through the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat <= 1'b0;
      end else if (en) begin
         sat <= f_sat;
      end
   end
`else
   // Wide enough that the selected window never runs off the top of acc.
   localparam int TW = (AW > SHIFT + OUT_W) ? AW : SHIFT + OUT_W;

   logic signed [TW-1:0] acc_ext;

   // Plain bit-window select: wraps on overflow, sign-extends if the window reaches past AW.
   always_comb begin
      acc_ext = TW'(acc);
      f_data  = OUT_W'(acc_ext >>> SHIFT);
   end

   assign sat = 1'b0;
`endif

   // S3: output register; holds data and valid while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         out_data  <= f_data;
         out_valid <= v2;
      end
   end

endmodule

// File: tb/tb_fir_filter_pipelined.sv
// Bench for fir_filter_pipelined: directed phases plus random traffic against a tap-sum reference model.
// One cycle per step; inputs change on the falling edge, outputs are sampled 1 ns later.
// The model computes each expected output from the accepted-sample window and the coefficients live when it is captured.
module tb_fir_filter_pipelined;

   localparam int NT = 15;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int OW = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic signed [DW-1:0]   in_data;
   logic                   in_ready;
   logic                   coef_we;
   logic [3:0]             coef_addr;
   logic signed [CW-1:0]   coef_data;
   logic                   out_valid;
   logic signed [OW-1:0]   out_data;
   logic                   out_ready;
   logic                   sat;

   fir_filter_pipelined #(.NTAPS(NT), .DW(DW), .CW(CW), .OUT_W(OW), .SHIFT(0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .sat(sat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic signed [DW-1:0] win [NT];
   logic signed [CW-1:0] cm  [NT];
   bit                   pending;
   logic signed [OW-1:0] exp_d [$];
   logic                 exp_s [$];
   logic signed [OW-1:0] obs_log [$];
   logic                 sat_log [$];
   bit                   acc_q [$];
   bit                   chk_lat = 0;
   bit                   prev_stall = 0;
   logic signed [OW-1:0] prev_data;
   int                   step_no = 0;
   int                   first_valid_step;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Tap sum at full precision, then the output mapping for SHIFT=0.
   function automatic void model_out(output logic signed [OW-1:0] d, output logic s);
      longint sum = 0;
      for (int k = 0; k < NT; k++) sum += longint'(win[k]) * longint'(cm[k]);
`ifdef FIR_SAT_EN
      if (sum > 64'sd2147483647) begin
         d = 32'sh7fffffff; s = 1'b1;
      end else if (sum < -64'sd2147483648) begin
         d = 32'sh80000000; s = 1'b1;
      end else begin
         d = 32'(sum); s = 1'b0;
      end
`else
      d = 32'(sum);
      s = 1'b0;
`endif
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NT; k++) begin win[k] = '0; cm[k] = '0; end
      pending = 0;
      exp_d.delete();
      exp_s.delete();
      prev_stall = 0;
   endtask

   // One clock: sample, score, advance model, cross the rising edge, return at the falling edge.
   task automatic step();
      logic rdy, ov, sv, s, acc;
      logic signed [OW-1:0] od, d;
      #1;
      rdy = in_ready; ov = out_valid; od = out_data; sv = sat;
      chk("in_ready", rdy, !ov || out_ready);
      if (prev_stall) begin
         chk("stall_valid", ov, 1'b1);
         chk("stall_data", od, prev_data);
      end
      if (chk_lat && acc_q.size() >= 4) chk("valid_pattern", ov, acc_q[acc_q.size()-4]);
      if (ov && first_valid_step < 0) first_valid_step = step_no;
      if (ov && out_ready) begin
         obs_log.push_back(od);
         sat_log.push_back(sv);
         if (exp_d.size() == 0) begin
            chk("unexpected_output", 1'b1, 1'b0);
         end else begin
            d = exp_d.pop_front();
            s = exp_s.pop_front();
            chk("out_data", od, d);
            chk("sat", sv, s);
         end
      end
      prev_stall = ov && !out_ready;
      prev_data  = od;
      acc = in_valid && rdy;
      // capture of the previously accepted sample uses coefficients from before this edge's write
      if (pending && rdy) begin
         model_out(d, s);
         exp_d.push_back(d);
         exp_s.push_back(s);
         pending = 0;
      end
      if (coef_we && coef_addr < NT) cm[coef_addr] = coef_data;
      if (acc) begin
         for (int k = NT - 1; k > 0; k--) win[k] = win[k-1];
         win[0] = in_data;
         pending = 1;
      end
      acc_q.push_back(acc);
      step_no++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic iv, input logic signed [DW-1:0] id, input logic ordy);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      coef_we   = 1'b0;
   endtask

   task automatic write_coef(input int addr, input logic signed [CW-1:0] val);
      drive(1'b0, '0, 1'b1);
      coef_we   = 1'b1;
      coef_addr = 4'(addr);
      coef_data = val;
      step();
      coef_we   = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int a;
      int idx;
      logic signed [OW-1:0] ovf_exp;
      logic                 ovf_sat;

      rst = 1'b1;
      drive(1'b0, '0, 1'b1);
      coef_addr = '0;
      coef_data = '0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_data", out_data, '0);
      chk("reset_sat", sat, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // out-of-range write first, then the ramp coefficients
      write_coef(15, 16'sd100);
      for (int k = 0; k < NT; k++) write_coef(k, 16'(k + 1));

      // impulse with a 5-cycle downstream stall in the middle
      obs_log.delete();
      first_valid_step = -1;
      a = step_no;
      drive(1'b1, 16'sd1, 1'b1);
      step();
      for (int i = 0; i < 6; i++) begin drive(1'b1, '0, 1'b1); step(); end
      for (int i = 0; i < 5; i++) begin drive(1'b1, '0, 1'b0); step(); end
      for (int i = 0; i < 20; i++) begin drive(1'b1, '0, 1'b1); step(); end
      // accept edge closes step a; three more edges put it in the output register
      chk("impulse_latency", 64'(first_valid_step - a), 64'd4);
      chk("impulse_count_ok", obs_log.size() >= 16, 1'b1);
      if (obs_log.size() >= 16)
         for (int k = 0; k < 16; k++) chk("impulse_resp", obs_log[k], (k < NT) ? 32'(k + 1) : 32'd0);

      // alternating bubbles, with coef[0] rewritten mid-stream
      acc_q.delete();
      chk_lat = 1;
      for (int i = 0; i < 24; i++) begin
         drive(i % 2 == 0, 16'($urandom), 1'b1);
         if (i == 10) begin
            coef_we = 1'b1; coef_addr = 4'd0; coef_data = -16'sd7;
         end
         step();
      end
      chk_lat = 0;

      // flush with zeros, then a fresh impulse must begin with the new coef[0]
      for (int i = 0; i < 20; i++) begin drive(1'b1, '0, 1'b1); step(); end
      obs_log.delete();
      drive(1'b1, 16'sd1, 1'b1);
      step();
      for (int i = 0; i < 12; i++) begin drive(1'b1, '0, 1'b1); step(); end
      idx = -1;
      for (int k = 0; k < obs_log.size(); k++)
         if (idx < 0 && obs_log[k] != 0) idx = k;
      if (idx < 0 || idx + 1 >= obs_log.size()) begin
         chk("impulse2_found", 1'b0, 1'b1);
      end else begin
         chk("impulse2_first", obs_log[idx], -32'sd7);
         chk("impulse2_second", obs_log[idx+1], 32'sd2);
      end

      // random traffic: data, bubbles, backpressure and coefficient writes
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            coef_we   = 1'b1;
            coef_addr = 4'($urandom_range(0, 15));
            coef_data = 16'($urandom);
         end
         step();
      end
      for (int i = 0; i < 10; i++) begin drive(1'b0, '0, 1'b1); step(); end
      chk("drain_random", exp_d.size(), 0);

      // full-scale input on full-scale coefficients
      for (int k = 0; k < NT; k++) write_coef(k, 16'sd32767);
      obs_log.delete();
      sat_log.delete();
      for (int i = 0; i < 20; i++) begin drive(1'b1, 16'sd32767, 1'b1); step(); end
      for (int i = 0; i < 6; i++) begin drive(1'b0, '0, 1'b1); step(); end
`ifdef FIR_SAT_EN
      ovf_exp = 32'sd2147483647;
      ovf_sat = 1'b1;
`else
      ovf_exp = -32'sd1074724849;
      ovf_sat = 1'b0;
`endif
      chk("overflow_count_ok", obs_log.size() == 20, 1'b1);
      if (obs_log.size() > 0) begin
         chk("overflow_data", obs_log[obs_log.size()-1], ovf_exp);
         chk("overflow_sat", sat_log[sat_log.size()-1], ovf_sat);
      end

      // reset in the middle of a cycle while streaming
      for (int i = 0; i < 8; i++) begin drive(1'b1, 16'($urandom), 1'b1); step(); end
      #2;
      chk("pre_reset_valid", out_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("midreset_out_valid", out_valid, 1'b0);
      chk("midreset_out_data", out_data, '0);
      chk("midreset_sat", sat, 1'b0);
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      obs_log.delete();
      drive(1'b1, 16'sd1, 1'b1);
      step();
      for (int i = 0; i < 10; i++) begin drive(1'b1, '0, 1'b1); step(); end
      chk("post_reset_count_ok", obs_log.size() >= 5, 1'b1);
      for (int k = 0; k < obs_log.size(); k++) chk("post_reset_zero", obs_log[k], '0);
      for (int i = 0; i < 6; i++) begin drive(1'b0, '0, 1'b1); step(); end
      chk("drain_final", exp_d.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
